// File: rtl/bsram_cpu_core.sv
// bsram_cpu_core: 8-bit accumulator CPU running from a 1-cycle-latency program BRAM, with a write-only VRAM port.
// Define CPU_TRACE_EN for a simulation-only instruction trace.
module bsram_cpu_core #(
  parameter int ADDR_W = 13,
  parameter int VADDR_W = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         dout,
  output logic [7:0]         din,
  output logic [ADDR_W-1:0]  ada,
  output logic               cea,
  output logic               ceb,
  output logic [ADDR_W-1:0]  adb,
  output logic [VADDR_W-1:0] v_ada,
  output logic               v_cea,
  output logic [7:0]         v_din
);
  // Every byte read walks ISSUE -> WAIT -> USE; the stage prefix says which byte is being read.
  typedef enum logic [3:0] {OP_I, OP_W, OP_U, B1_I, B1_W, B1_U, B2_I, B2_W, B2_U, D_I, D_W, D_U, WR, HALT} state_t;
  state_t st, nx;
  logic [ADDR_W-1:0] pc, pc_n, ea, ea_n, ada_n, adb_n;
  logic [VADDR_W-1:0] v_ada_n;
  logic [7:0] a, a_n, x, x_n, ir, ir_n, din_n, v_din_n;
  logic z, z_n, c, c_n, cea_n, ceb_n, v_cea_n;
  logic [8:0] sum;
  assign sum = {1'b0, a} + {1'b0, dout};
  function automatic logic one_b(input logic [7:0] op);
    return op inside {8'h01, 8'h02, 8'h05, 8'h06, 8'h0C};
  endfunction
  function automatic logic two_b(input logic [7:0] op);
    return op inside {8'h03, 8'h04, 8'h09, 8'h0A, 8'h0B};
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= OP_I;
      pc <= RESET_PC;
      ea <= '0;
      a <= '0;
      x <= '0;
      ir <= '0;
      z <= 1'b0;
      c <= 1'b0;
      din <= '0;
      ada <= '0;
      cea <= 1'b0;
      ceb <= 1'b0;
      adb <= '0;
      v_ada <= '0;
      v_cea <= 1'b0;
      v_din <= '0;
    end else begin
      st <= nx;
      pc <= pc_n;
      ea <= ea_n;
      a <= a_n;
      x <= x_n;
      ir <= ir_n;
      z <= z_n;
      c <= c_n;
      din <= din_n;
      ada <= ada_n;
      cea <= cea_n;
      ceb <= ceb_n;
      adb <= adb_n;
      v_ada <= v_ada_n;
      v_cea <= v_cea_n;
      v_din <= v_din_n;
    end
  always_comb begin
    nx = state_t'(st + 4'd1);
    case (st)
      OP_U: nx = dout == 8'h0D ? HALT : (one_b(dout) || two_b(dout)) ? B1_I : OP_I;
      B1_U: nx = two_b(ir) ? B2_I : OP_I;
      B2_U: nx = ir == 8'h03 ? D_I : (ir == 8'h04 || ir == 8'h0B) ? WR : OP_I;
      D_U, WR: nx = OP_I;
      HALT: nx = HALT;
      default: ;
    endcase
  end
  always_comb begin
    pc_n = pc;
    ea_n = ea;
    a_n = a;
    x_n = x;
    ir_n = ir;
    z_n = z;
    c_n = c;
    din_n = din;
    ada_n = ada;
    cea_n = 1'b0;
    ceb_n = 1'b0;
    adb_n = adb;
    v_ada_n = v_ada;
    v_cea_n = 1'b0;
    v_din_n = v_din;
    case (st)
      OP_I, B1_I, B2_I: begin
        adb_n = pc;
        ceb_n = 1'b1;
        pc_n = pc + 1'b1;
      end
      D_I: begin
        adb_n = ea;
        ceb_n = 1'b1;
      end
      OP_U: begin
        ir_n = dout;
        if (dout == 8'h07 || dout == 8'h08) begin
          x_n = dout == 8'h07 ? x + 8'd1 : x - 8'd1;
          z_n = x_n == 8'd0;
        end
      end
      B1_U: begin
        ea_n[7:0] = dout;
        case (ir)
          8'h01: begin a_n = dout; z_n = dout == 8'd0; end
          8'h02: begin x_n = dout; z_n = dout == 8'd0; end
          8'h05: begin {c_n, a_n} = sum; z_n = sum[7:0] == 8'd0; end
          8'h06: begin a_n = a - dout; c_n = a >= dout; z_n = a == dout; end
          8'h0C: begin v_cea_n = 1'b1; v_ada_n = VADDR_W'(x) + VADDR_W'(dout); v_din_n = a; end
          default: ;
        endcase
      end
      B2_U: begin
        ea_n = ADDR_W'({dout, ea[7:0]});
        if (ir == 8'h09 || (ir == 8'h0A && !z)) pc_n = ADDR_W'({dout, ea[7:0]});
      end
      D_U: begin
        a_n = dout;
        z_n = dout == 8'd0;
      end
      WR:
        if (ir == 8'h04) begin
          cea_n = 1'b1;
          ada_n = ea;
          din_n = a;
        end else begin
          v_cea_n = 1'b1;
          v_ada_n = ea[VADDR_W-1:0];
          v_din_n = a;
        end
      default: ;
    endcase
  end
`ifdef CPU_TRACE_EN
  logic [ADDR_W-1:0] op_pc;
  always @(posedge clk) begin
    if (st == OP_I) op_pc <= pc;
    if (!rst && st != OP_I && st != HALT && (nx == OP_I || nx == HALT))
      $display("trace pc=%h ir=%h a=%h x=%h z=%b c=%b", op_pc, ir_n, a_n, x_n, z_n, c_n);
    if (!rst && st != HALT && nx == HALT) $display("HALT");
  end
`endif
endmodule

// File: tb/tb_bsram_cpu_core.sv
// tb_bsram_cpu_core: directed and random programs checked against an instruction-level model of the CPU.
module tb_bsram_cpu_core;
  typedef logic [38:0] wr_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] dout = 8'h00, din, v_din;
  logic [12:0] ada, adb;
  logic [9:0] v_ada;
  logic cea, ceb, v_cea;
  logic ld = 1'b0;
  logic [12:0] ld_a = '0;
  logic [7:0] ld_d = '0;
  logic [7:0] mem [0:8191];
  logic [7:0] mm [0:8191];
  logic [7:0] p [$];
  wr_t expq [$], obs [$];
  int errors = 0, checks = 0, halt_cyc = 0, last_ceb = 0, post = 0;

  bsram_cpu_core dut (
    .clk(clk), .rst(rst), .dout(dout), .din(din), .ada(ada), .cea(cea), .ceb(ceb),
    .adb(adb), .v_ada(v_ada), .v_cea(v_cea), .v_din(v_din)
  );

  always #5 clk = ~clk;

  // Program RAM: port A write, port B registered read; ld lets the bench preload it.
  always @(posedge clk) begin
    if (ld) mem[ld_a] = ld_d;
    else if (cea) mem[ada] = din;
    if (ceb) dout <= mem[adb];
  end

  function automatic logic [63:0] outs();
    return {din, ada, cea, ceb, adb, v_ada, v_cea, v_din};
  endfunction

  function automatic int len_of(input logic [7:0] op);
    return op inside {8'h01, 8'h02, 8'h05, 8'h06, 8'h0C} ? 1 : op inside {8'h03, 8'h04, 8'h09, 8'h0A, 8'h0B} ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic want(input string tag, input int i, input wr_t v);
    check(tag, i < obs.size() ? obs[i] : '0, v);
  endtask

  task automatic put(input logic [12:0] a, input logic [7:0] d);
    mm[a] = d;
    ld_a = a;
    ld_d = d;
    ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
  endtask

  task automatic load();
    for (int i = 0; i < 16; i++) put(13'h1000 + 13'(i), 8'($urandom));
    for (int i = 0; i < p.size(); i++) put(13'(i), p[i]);
  endtask

  // Instruction-level model: executes whole instructions and schedules each write at its instruction's last cycle.
  task automatic iss(input int budget);
    logic [12:0] pc, ad;
    logic [7:0] a, x, op, b1, b2;
    logic z;
    int t, n;
    bit h;
    pc = '0; a = '0; x = '0; z = 1'b0; t = 0; h = 1'b0; halt_cyc = 0;
    expq.delete();
    while (!h && t < budget) begin
      op = mm[pc];
      b1 = mm[pc + 13'd1];
      b2 = mm[pc + 13'd2];
      ad = {b2[4:0], b1};
      pc = pc + 13'(1 + len_of(op));
      n = 3;
      case (op)
        8'h01: begin a = b1; z = a == 0; n = 6; end
        8'h02: begin x = b1; z = x == 0; n = 6; end
        8'h03: begin a = mm[ad]; z = a == 0; n = 12; end
        8'h04: begin
          mm[ad] = a; n = 10;
          if (t + n <= budget) expq.push_back({16'(t + n), 2'b01, ad, a});
        end
        8'h05: begin a = a + b1; z = a == 0; n = 6; end
        8'h06: begin a = a - b1; z = a == 0; n = 6; end
        8'h07: begin x = x + 1; z = x == 0; end
        8'h08: begin x = x - 1; z = x == 0; end
        8'h09: begin pc = ad; n = 9; end
        8'h0A: begin if (!z) pc = ad; n = 9; end
        8'h0B: begin
          n = 10;
          if (t + n <= budget) expq.push_back({16'(t + n), 2'b10, 13'(ad[9:0]), a});
        end
        8'h0C: begin
          n = 6;
          if (t + n <= budget) expq.push_back({16'(t + n), 2'b10, 13'(10'(x) + 10'(b1)), a});
        end
        8'h0D: begin h = 1'b1; if (t + 3 <= budget) halt_cyc = t + 3; end
        default: ;
      endcase
      t += n;
    end
  endtask

  task automatic run(input int budget);
    wr_t w, e;
    iss(budget);
    check("reset_outputs", outs(), 64'd0);
    obs.delete();
    last_ceb = 0;
    post = 0;
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check("first_issue", {ceb, adb}, {1'b1, 13'h0000});
      if (ceb) last_ceb = k;
      if (cea || v_cea) begin
        w = {16'(k), v_cea, cea, v_cea ? {3'b000, v_ada} : ada, v_cea ? v_din : din};
        e = '0;
        if (expq.size() != 0) e = expq.pop_front();
        obs.push_back(w);
        check("write", w, e);
        check("no_read_on_write", ceb, 1'b0);
      end
      if (halt_cyc != 0 && k > halt_cyc && (ceb || cea || v_cea)) post++;
    end
    check("missing_writes", expq.size(), 0);
    if (halt_cyc != 0) begin
      check("halt_last_fetch", last_ceb, halt_cyc - 2);
      check("idle_after_halt", post, 0);
    end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic gen();
    logic [7:0] ops [$];
    int bnd [$];
    int pos = 0;
    int j;
    logic [7:0] op;
    logic [12:0] ad;
    p.delete();
    repeat ($urandom_range(8, 16)) begin
      j = $urandom_range(0, 13);
      op = j == 13 ? 8'($urandom_range(14, 255)) : 8'(j);
      ops.push_back(op);
      bnd.push_back(pos);
      pos += 1 + len_of(op);
    end
    ops.push_back(8'h0D);
    bnd.push_back(pos);
    foreach (ops[i]) begin
      p.push_back(ops[i]);
      ad = ops[i] inside {8'h03, 8'h04} ? 13'h1000 | 13'($urandom_range(0, 15))
         : ops[i] == 8'h09 ? 13'(bnd[$urandom_range(i + 1, bnd.size() - 1)])
         : ops[i] == 8'h0A ? 13'(bnd[$urandom_range(0, bnd.size() - 1)])
         : 13'($urandom);
      if (len_of(ops[i]) == 1) p.push_back(8'($urandom));
      if (len_of(ops[i]) == 2) begin
        p.push_back(ad[7:0]);
        p.push_back({3'($urandom), ad[12:8]});
      end
    end
  endtask

  initial begin
    p = '{8'h01, 8'h41, 8'h0B, 8'h00, 8'h00, 8'h0D};
    load();
    run(40);
    check("t1_count", obs.size(), 1);
    want("t1_stv", 0, {16'd16, 2'b10, 13'h000, 8'h41});

    p = '{8'h01, 8'hF0, 8'h05, 8'h20, 8'h0B, 8'h00, 8'h00, 8'h06, 8'h10, 8'h0B, 8'h01, 8'h00,
          8'h0A, 8'h12, 8'h00, 8'h0B, 8'h02, 8'h00, 8'h0D};
    load();
    run(70);
    want("t2_add", 0, {16'd22, 2'b10, 13'h000, 8'h10});
    want("t2_sub", 1, {16'd38, 2'b10, 13'h001, 8'h00});
    want("t2_bne_not_taken", 2, {16'd57, 2'b10, 13'h002, 8'h00});

    p = '{8'h02, 8'h03, 8'h08, 8'h0A, 8'h02, 8'h00, 8'h0D};
    load();
    run(60);
    check("t3_no_writes", obs.size(), 0);
    check("t3_halt_fetch", last_ceb, 43);

    p = '{8'h01, 8'h5A, 8'h04, 8'h00, 8'h10, 8'h01, 8'h00, 8'h03, 8'h00, 8'h10, 8'h0B, 8'h05, 8'h00, 8'h0D};
    load();
    run(60);
    want("t4_sta", 0, {16'd16, 2'b01, 13'h1000, 8'h5A});
    want("t4_readback", 1, {16'd44, 2'b10, 13'h005, 8'h5A});

    p = '{8'h02, 8'hFF, 8'h01, 8'h7E, 8'h0C, 8'h10, 8'hFF, 8'h0C, 8'h11, 8'h0D};
    load();
    run(40);
    want("t5_stvx", 0, {16'd18, 2'b10, 13'h10F, 8'h7E});
    want("t5_nop_ff", 1, {16'd27, 2'b10, 13'h110, 8'h7E});

    p = '{8'h01, 8'h5A, 8'h04, 8'h00, 8'h10, 8'h0D};
    load();
    @(negedge clk) rst = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1 check("rst_async", outs(), 64'd0);
    @(posedge clk);
    #1 check("rst_no_sta", outs(), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("restart_issue", {ceb, adb}, {1'b1, 13'h0000});
    @(negedge clk) rst = 1'b1;

    for (int r = 0; r < 8; r++) begin
      gen();
      load();
      run(400);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
